spart_bus_if: RTL and testbench

//  Processor-facing register/bus responder of the SPART. Decodes iocs_n/iorw_n/ioaddr

---
 rtl/spart_pkg.sv | 21 ++
 rtl/spart_queue.sv | 59 +++++
 rtl/spart_bus_if.sv | 104 ++++++++++
 tb/tb_spart_bus_if.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor bus interface.
//  - ioaddr_e      : register map of the 2-bit ioaddr field
//  - DB_RESET_DEF  : default baud divisor (50 MHz, 16x oversampling, 9600 baud)
//  - STAT_*        : field positions inside the status byte
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_BUF    = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DB_LO  = 2'b10,
    ADDR_DB_HI  = 2'b11
  } ioaddr_e;

  localparam logic [15:0] DB_RESET_DEF = 16'h0145;

  // status = {TX free entries, RX occupied entries}
  localparam int STAT_TX_LSB  = 4;
  localparam int STAT_RX_LSB  = 0;
  localparam int STAT_FIELD_W = 4;

endpackage

// File: rtl/spart_queue.sv
// Synchronous FIFO used for both the TX and RX byte queues.
//  clk, rst      : clock, async active-high reset (empties the queue)
//  push/push_data: enqueue request; accepted if not full or if a pop happens
//                  in the same cycle
//  pop           : dequeue request; ignored when empty
//  head          : oldest entry, forced to 0 when empty
//  count         : occupancy, 0..DEPTH
//  full/empty    : decoded from count (not from pointer compare)
module spart_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full queue still takes a byte when its head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spart_bus_if.sv
// SPART processor-facing bus responder.
//  iocs_n/iorw_n/ioaddr/databus : level-based register bus, one transaction
//                                 per rising clk while iocs_n=0
//  tx_data/tx_valid/tx_ready    : TX queue head toward the serial transmitter
//  tx_q_full                    : TX queue holds DEPTH bytes
//  rx_data/rx_valid             : byte push from the serial receiver
//  rx_q_empty                   : RX queue holds no bytes
//  rx_overrun                   : 1-cycle pulse when an RX byte was dropped
//  divisor/divisor_wr           : baud divisor and its 1-cycle update pulse
module spart_bus_if
  import spart_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] DB_RESET = DB_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iocs_n,
  input  logic        iorw_n,
  input  logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  output logic        tx_q_full,
  output logic        rx_q_empty,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] divisor,
  output logic        divisor_wr,
  output logic        rx_overrun
);

  localparam int CW = $clog2(DEPTH) + 1;

  ioaddr_e       addr;
  logic          cpu_rd, cpu_wr;
  logic          tx_push, rx_pop, rx_drop;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count, tx_free;
  logic [7:0]    rx_head, rd_data, status;
  logic [7:0]    db_lo, db_hi;

  assign addr    = ioaddr_e'(ioaddr);
  assign cpu_rd  = !iocs_n &&  iorw_n;
  assign cpu_wr  = !iocs_n && !iorw_n;
  assign tx_push = cpu_wr && (addr == ADDR_BUF);
  assign rx_pop  = cpu_rd && (addr == ADDR_BUF);
  // When RX is full a CPU pop is always effective, so it frees the slot.
  assign rx_drop = rx_valid && rx_full && !rx_pop;

  spart_queue #(.DEPTH(DEPTH), .WIDTH(8)) u_txq (
    .clk(clk), .rst(rst),
    .push(tx_push), .push_data(databus), .pop(tx_ready),
    .head(tx_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  spart_queue #(.DEPTH(DEPTH), .WIDTH(8)) u_rxq (
    .clk(clk), .rst(rst),
    .push(rx_valid), .push_data(rx_data), .pop(rx_pop),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  assign tx_q_full  = tx_full;
  assign tx_valid   = !tx_empty;
  assign rx_q_empty = rx_empty;
  assign divisor    = {db_hi, db_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_lo      <= DB_RESET[7:0];
      db_hi      <= DB_RESET[15:8];
      divisor_wr <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (cpu_wr && addr == ADDR_DB_LO) db_lo <= databus;
      if (cpu_wr && addr == ADDR_DB_HI) db_hi <= databus;
      divisor_wr <= cpu_wr && (addr == ADDR_DB_LO || addr == ADDR_DB_HI);
      rx_overrun <= rx_drop;
    end
  end

  assign tx_free = CW'(DEPTH) - tx_count;

  always_comb begin
    status = '0;
    status[STAT_TX_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(tx_free);
    status[STAT_RX_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(rx_count);
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_BUF:    rd_data = rx_head;  // 0 when RX is empty
      ADDR_STATUS: rd_data = status;
      ADDR_DB_LO:  rd_data = db_lo;
      ADDR_DB_HI:  rd_data = db_hi;
      default:     rd_data = '0;
    endcase
  end

  assign databus = cpu_rd ? rd_data : 8'bz;

endmodule

// File: tb/tb_spart_bus_if.sv
// Directed bench for spart_bus_if: a vector table for single-cycle bus
// accesses plus hand-written queue fill/drain and overrun sequences.
// The bus has a pull-up, so an undriven databus reads 8'hFF.
module tb_spart_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        iocs_n, iorw_n;
  logic [1:0]  ioaddr;
  tri1  [7:0]  databus;
  logic        tx_q_full, rx_q_empty, tx_valid, tx_ready;
  logic [7:0]  tx_data, rx_data;
  logic        rx_valid;
  logic [15:0] divisor;
  logic        divisor_wr, rx_overrun;

  logic        drv_en;
  logic [7:0]  drv_val;

  int checks = 0;
  int errors = 0;

  assign databus = drv_en ? drv_val : 8'bz;

  always #5 clk = ~clk;

  spart_bus_if dut (
    .clk(clk), .rst(rst), .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr),
    .databus(databus), .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .divisor(divisor),
    .divisor_wr(divisor_wr), .rx_overrun(rx_overrun)
  );

  typedef struct {
    logic        cs_n;
    logic        rw_n;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_bus;
    logic        exp_txv;
    logic        exp_rxe;
    logic [15:0] exp_div;
    logic        exp_dwr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    iocs_n = 1'b1; iorw_n = 1'b1; ioaddr = 2'b00; drv_en = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs_n = 1'b0; iorw_n = 1'b0; ioaddr = a; drv_en = 1'b1; drv_val = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs_n = 1'b0; iorw_n = 1'b1; ioaddr = a; drv_en = 1'b0;
    #1 d = databus;
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    logic [7:0] rd;

    //          cs rw addr  wdata  bus    txv rxe div       dwr
    vecs[0]  = '{1, 1, 2'b01, 8'h00, 8'hFF, 0, 1, 16'h0145, 0};
    vecs[1]  = '{0, 1, 2'b01, 8'h00, 8'h80, 0, 1, 16'h0145, 0};
    vecs[2]  = '{0, 1, 2'b10, 8'h00, 8'h45, 0, 1, 16'h0145, 0};
    vecs[3]  = '{0, 1, 2'b11, 8'h00, 8'h01, 0, 1, 16'h0145, 0};
    vecs[4]  = '{0, 0, 2'b10, 8'h58, 8'h58, 0, 1, 16'h0158, 1};
    vecs[5]  = '{0, 0, 2'b11, 8'h14, 8'h14, 0, 1, 16'h1458, 1};
    vecs[6]  = '{0, 1, 2'b10, 8'h00, 8'h58, 0, 1, 16'h1458, 0};
    vecs[7]  = '{0, 1, 2'b11, 8'h00, 8'h14, 0, 1, 16'h1458, 0};
    vecs[8]  = '{1, 0, 2'b10, 8'h77, 8'h77, 0, 1, 16'h1458, 0};
    vecs[9]  = '{1, 1, 2'b00, 8'h00, 8'hFF, 0, 1, 16'h1458, 0};
    vecs[10] = '{0, 0, 2'b01, 8'h33, 8'h33, 0, 1, 16'h1458, 0};
    vecs[11] = '{0, 1, 2'b01, 8'h00, 8'h80, 0, 1, 16'h1458, 0};
    vecs[12] = '{0, 0, 2'b00, 8'hAA, 8'hAA, 1, 1, 16'h1458, 0};
    vecs[13] = '{0, 1, 2'b01, 8'h00, 8'h70, 1, 1, 16'h1458, 0};
    vecs[14] = '{1, 0, 2'b00, 8'hBB, 8'hBB, 1, 1, 16'h1458, 0};
    vecs[15] = '{0, 1, 2'b01, 8'h00, 8'h70, 1, 1, 16'h1458, 0};
    vecs[16] = '{1, 1, 2'b01, 8'h00, 8'hFF, 1, 1, 16'h1458, 0};

    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; drv_val = 8'h00;
    bus_idle();

    // Reset state
    #12;
    chk("rst_tx_q_full",  tx_q_full,  0);
    chk("rst_rx_q_empty", rx_q_empty, 1);
    chk("rst_tx_valid",   tx_valid,   0);
    chk("rst_tx_data",    tx_data,    0);
    chk("rst_divisor",    divisor,    16'h0145);
    chk("rst_divisor_wr", divisor_wr, 0);
    chk("rst_rx_overrun", rx_overrun, 0);
    chk("rst_databus_z",  databus,    8'hFF);
    @(negedge clk);
    rst = 1'b0;

    // Table: register access, decode and chip-select gating
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      iocs_n = vecs[i].cs_n; iorw_n = vecs[i].rw_n; ioaddr = vecs[i].addr;
      drv_en = !vecs[i].rw_n; drv_val = vecs[i].wdata;
      #1 chk($sformatf("vec%0d_bus", i), databus, vecs[i].exp_bus);
      @(negedge clk);
      bus_idle();
      chk($sformatf("vec%0d_txv", i), tx_valid,   vecs[i].exp_txv);
      chk($sformatf("vec%0d_rxe", i), rx_q_empty, vecs[i].exp_rxe);
      chk($sformatf("vec%0d_div", i), divisor,    vecs[i].exp_div);
      chk($sformatf("vec%0d_dwr", i), divisor_wr, vecs[i].exp_dwr);
    end
    chk("tx_head_aa", tx_data, 8'hAA);

    // Reset mid-operation discards the TX byte and restores the divisor
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_tx_valid", tx_valid, 0);
    chk("rst2_divisor",  divisor,  16'h0145);
    @(negedge clk);
    rst = 1'b0;

    // TX fill to full, 9th byte dropped, drain in order
    for (int i = 0; i < 8; i++) bus_write(2'b00, 8'h10 + 8'(i));
    chk("tx_full", tx_q_full, 1);
    bus_read(2'b01, rd);
    chk("status_tx_full", rd, 8'h00);
    bus_write(2'b00, 8'h99);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_pop%0d_valid", i), tx_valid, 1);
      chk($sformatf("tx_pop%0d_data", i),  tx_data,  8'h10 + 8'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 0);
    chk("tx_not_full", tx_q_full, 0);

    // RX fill with A0..A7 then CPU drain
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rx_not_empty", rx_q_empty, 0);
    bus_read(2'b01, rd);
    chk("status_rx_full", rd, 8'h88);
    for (int i = 0; i < 8; i++) begin
      bus_read(2'b00, rd);
      chk($sformatf("rx_rd%0d", i), rd, 8'hA0 + 8'(i));
    end
    chk("rx_empty", rx_q_empty, 1);
    bus_read(2'b00, rd);
    chk("rx_rd_empty", rd, 8'h00);
    bus_read(2'b01, rd);
    chk("status_idle", rd, 8'h80);

    // RX overrun: full queue drops CC; full + CPU read accepts DD
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hB0 + 8'(i);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'hCC;
    chk("ovr_idle_before", rx_overrun, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("ovr_pulse", rx_overrun, 1);
    @(negedge clk);
    chk("ovr_pulse_end", rx_overrun, 0);

    rx_valid = 1'b1; rx_data = 8'hDD;
    iocs_n = 1'b0; iorw_n = 1'b1; ioaddr = 2'b00;
    #1 chk("full_rd_head", databus, 8'hB0);
    @(negedge clk);
    rx_valid = 1'b0;
    bus_idle();
    chk("full_rd_no_ovr", rx_overrun, 0);
    bus_read(2'b01, rd);
    chk("full_rd_count8", rd, 8'h88);
    for (int i = 1; i < 8; i++) begin
      bus_read(2'b00, rd);
      chk($sformatf("ovr_rd%0d", i), rd, 8'hB0 + 8'(i));
    end
    bus_read(2'b00, rd);
    chk("ovr_rd_tail_dd", rd, 8'hDD);
    chk("ovr_final_empty", rx_q_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
